// File: rtl/keypad_pkg.sv
// Shared keypad definitions: row/column one-hot codes, named key codes, scanner states.
// Used by keypad_scanner and the downstream keypad letter FSM.
package keypad_pkg;

    localparam logic [3:0] ROW0 = 4'b1000;
    localparam logic [3:0] ROW1 = 4'b0100;
    localparam logic [3:0] ROW2 = 4'b0010;
    localparam logic [3:0] ROW3 = 4'b0001;

    localparam logic [3:0] COL0 = 4'b1000;
    localparam logic [3:0] COL1 = 4'b0100;
    localparam logic [3:0] COL2 = 4'b0010;
    localparam logic [3:0] COL3 = 4'b0001;

    localparam logic [7:0] KEY_SUBMIT_LETTER = 8'b00011000;  // R3C0
    localparam logic [7:0] KEY_CLEAR         = 8'b00010100;  // R3C1
    localparam logic [7:0] KEY_SUBMIT_WORD   = 8'b00010010;  // R3C2
    localparam logic [7:0] KEY_GAME_END      = 8'b00100001;  // R2C3

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } scan_state_e;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // R0 -> R1 -> R2 -> R3 -> R0, i.e. shift right with wrap.
    function automatic logic [3:0] rotate_row(input logic [3:0] r);
        return {r[0], r[3:1]};
    endfunction

endpackage

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous inputs.
module sync2 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column sampling, press/release debounce, press strobe.
// Optional auto-repeat strobes while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 16,
    parameter int unsigned DEBOUNCE_CNT = 1000,
    parameter int unsigned REPEAT_CNT   = 50000
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [7:0] cur_key,
    output logic       strobe,
    output logic       key_valid
);

    localparam int unsigned MaxAB    = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int unsigned MaxParam = (MaxAB > REPEAT_CNT) ? MaxAB : REPEAT_CNT;
    localparam int unsigned CntW     = $clog2(MaxParam + 1);

    localparam logic [CntW-1:0] DwellLast = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] DebLast   = CntW'(DEBOUNCE_CNT - 1);

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (v == {CntW{1'b1}}) ? v : v + CntW'(1);
    endfunction

    logic [3:0] col_s;

    sync2 #(
        .WIDTH(4)
    ) u_col_sync (
        .clk (clk),
        .nRst(nRst),
        .d_i (col_in),
        .q_o (col_s)
    );

    scan_state_e     state_q, state_d;
    logic [3:0]      row_q, row_d;
    logic [CntW-1:0] dwell_q, dwell_d;
    logic [CntW-1:0] deb_q, deb_d;
    logic [CntW-1:0] rel_q, rel_d;
    logic [7:0]      cand_q, cand_d;
    logic [7:0]      cur_key_q, cur_key_d;
    logic            strobe_q, strobe_d;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CntW-1:0] RepLast = CntW'(REPEAT_CNT - 1);
    logic [CntW-1:0] rep_q, rep_d;
`endif

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        dwell_d   = dwell_q;
        deb_d     = deb_q;
        rel_d     = rel_q;
        cand_d    = cand_q;
        cur_key_d = cur_key_q;
        strobe_d  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d     = rep_q;
`endif
        unique case (state_q)
            SCAN: begin
                if (dwell_q == DwellLast) begin
                    dwell_d = '0;
                    // Zero or multi-column samples (ghosting) are ignored.
                    if (is_onehot4(col_s)) begin
                        cand_d  = {row_q, col_s};
                        deb_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        row_d = rotate_row(row_q);
                    end
                end else begin
                    dwell_d = sat_inc(dwell_q);
                end
            end
            DEBOUNCE: begin
                if (col_s == cand_q[3:0]) begin
                    if (deb_q >= DebLast) begin
                        cur_key_d = cand_q;
                        strobe_d  = 1'b1;
                        rel_d     = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d     = '0;
`endif
                        state_d   = HELD;
                    end else begin
                        deb_d = sat_inc(deb_q);
                    end
                end else begin
                    deb_d   = '0;
                    dwell_d = '0;
                    row_d   = rotate_row(row_q);
                    state_d = SCAN;
                end
            end
            HELD: begin
                if (col_s == 4'd0) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_d = '0;
`endif
                    if (rel_q >= DebLast) begin
                        cur_key_d = 8'd0;
                        rel_d     = '0;
                        dwell_d   = '0;
                        row_d     = rotate_row(row_q);
                        state_d   = SCAN;
                    end else begin
                        rel_d = sat_inc(rel_q);
                    end
                end else begin
                    // Any activity, even another column, restarts the release count.
                    rel_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (rep_q >= RepLast) begin
                        rep_d    = '0;
                        strobe_d = 1'b1;
                    end else begin
                        rep_d = sat_inc(rep_q);
                    end
`endif
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= SCAN;
            row_q     <= ROW0;
            dwell_q   <= '0;
            deb_q     <= '0;
            rel_q     <= '0;
            cand_q    <= 8'd0;
            cur_key_q <= 8'd0;
            strobe_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            dwell_q   <= dwell_d;
            deb_q     <= deb_d;
            rel_q     <= rel_d;
            cand_q    <= cand_d;
            cur_key_q <= cur_key_d;
            strobe_q  <= strobe_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

    assign row_out   = row_q;
    assign cur_key   = cur_key_q;
    assign strobe    = strobe_q;
    assign key_valid = (cur_key_q != 8'd0);

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Sequences the 4x4 matrix keypad: drives one-hot rows, samples columns, debounces, and emits a one-hot {row,col} key code plus a single-cycle press strobe.
- Sits between the keypad pins and the keypad letter FSM.
- Its cur_key/strobe outputs are that FSM's cur_key/strobe inputs.
- cur_key is level-valid while the key is held and 8'd0 when no key is held.

Parameters:
- SCAN_DIV, 16: clk cycles each row is driven before advancing (dwell); min 3.
- DEBOUNCE_CNT, 1000: consecutive stable cycles required to accept a press or a release; min 1.
- REPEAT_CNT, 50000: hold cycles between auto-repeat strobes; used only with KEYPAD_AUTOREPEAT_EN.

Ports:
- clk  input  1  system clock
- nRst  input  1  asynchronous active-low reset
- col_in  input  4  raw column lines, active-high, asynchronous to clk; bit3=C0 .. bit0=C3
- row_out  output  4  one-hot row drive, active-high; bit3=R0 .. bit0=R3
- cur_key  output  8  {row_onehot[3:0], col_onehot[3:0]} of the accepted key, else 8'd0
- strobe  output  1  one-cycle pulse on each accepted press
- key_valid  output  1  high while cur_key is nonzero

Behaviour:
- Reset (nRst low, async):
  - state=SCAN, row_out=4'b1000 (R0), cur_key=8'd0, strobe=0, key_valid=0.
  - All counters and synchronizer flops are cleared.
  - Reset mid-press returns to SCAN with no strobe emitted.
- col_in passes through a 2-flop synchronizer; col_s is the synchronized value.
  - All decisions use col_s.
  - There are 2 cycles of input latency.
- Counters are unsigned, width $clog2(max param+1). They saturate and never wrap.
- SCAN state:
  - dwell_cnt counts 0..SCAN_DIV-1 per row.
  - On dwell_cnt==SCAN_DIV-1, col_s is sampled, then the row rotates R0->R1->R2->R3->R0 (row_out shifts right and wraps from 4'b0001 to 4'b1000).
  - Sample with exactly one col bit set: store cand={row_out,col_s}, freeze row_out, clear deb_cnt, go to DEBOUNCE.
  - Sample of zero or with >1 bit set (ghosting / multi-press): ignore and keep scanning.
- DEBOUNCE state:
  - Each cycle col_s==cand[3:0] increments deb_cnt.
  - Any mismatch: clear deb_cnt, go to SCAN, advance to the next row. No output change.
  - When deb_cnt reaches DEBOUNCE_CNT-1 with a match: next cycle cur_key=cand, key_valid=1, strobe=1 for exactly that cycle; go to HELD.
- HELD state:
  - row_out stays frozen and cur_key is held.
  - Cycles with col_s==0 increment rel_cnt; any nonzero col_s clears rel_cnt.
  - This includes a different column: a second key is never accepted while one is held.
  - When rel_cnt reaches DEBOUNCE_CNT-1: next cycle cur_key=0, key_valid=0, go to SCAN resuming at the next row.
  - The release produces no strobe.
- Strobe behaviour:
  - Registered; never high two consecutive cycles.
  - Never high while cur_key==0.
  - Never high on release.
- Latency: press stable at col_in -> strobe is at most 2 + 4*SCAN_DIV + DEBOUNCE_CNT + 1 cycles.

Optional Feature:
- Macro KEYPAD_AUTOREPEAT_EN.
- Defined: in HELD, rep_cnt counts held cycles.
  - At REPEAT_CNT-1 it emits another 1-cycle strobe with unchanged cur_key and restarts.
  - rep_cnt clears on entering HELD and on any release-count activity (col_s==0).
- Undefined: exactly one strobe per press; rep_cnt logic is absent.

Decomposition:
- Shared package keypad_pkg holds:
  - Row one-hot constants ROW0..ROW3 = 4'b1000..4'b0001 and column constants COL0..COL3 = 4'b1000..4'b0001.
  - Named key codes: submit-letter R3C0=8'b00011000, clear R3C1=8'b00010100, submit-word R3C2=8'b00010010, game-end R2C3=8'b00100001.
  - The scanner state enum {SCAN, DEBOUNCE, HELD}.
  - The letter FSM also imports keypad_pkg.
- One sub-module, sync2: a parameterized-width 2-flop synchronizer with async active-low reset.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CNT=20.
- Reset, no keys for 40 cycles -> row_out cycles 1000,0100,0010,0001 every 4 cycles; cur_key=0; strobe never high.
- Hold col_in=4'b1000 only while row R2 is driven, stable -> exactly one strobe; cur_key=8'b00101000; key_valid high until 8 cycles after col_in=0; then cur_key=0 with no strobe.
- Bounce col_in 1000/0000 every 3 cycles for 30 cycles, then stable -> no strobe during bounce; exactly one strobe after stable press debounced.
- col_in=4'b1010 (two columns) on one row -> no strobe, scanning continues.
- Assert nRst mid-DEBOUNCE and again mid-HELD -> outputs return to reset values at once; no strobe after release of nRst until a fresh debounced press.
- With KEYPAD_AUTOREPEAT_EN: hold R3C0 for 70 cycles after acceptance -> strobes at acceptance plus every 20 cycles (4 total); cur_key=8'b00011000 throughout. Without the macro -> 1 strobe.
